regf_rsp: RTL

REGF_RSP -- requirements
Module: regf_rsp

---
 rtl/regf_rsp.sv | 103 ++++++++++
 1 files changed

// File: rtl/regf_rsp.sv
// rtl/regf_rsp.sv - register file with 1-cycle read response, write-first bypass and sequenced clear
module regf_rsp #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_e,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_hit,
    input  logic          clr,
    output logic          busy,
    output logic          clr_done
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic            r_rd_valid;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_hit;

    logic w_busy;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_bypass;

    assign w_busy   = (r_state == S_CLEAR);
    assign w_wr_acc = wr_e & ~w_busy;
    assign w_rd_acc = rd_req & ~w_busy;
    assign w_bypass = w_wr_acc && (wr_addr == rd_addr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clr) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_idx == {AW{1'b1}}) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // idx only advances while clearing, so it is 0 on entry to CLEAR
            if (r_state == S_CLEAR) r_idx <= r_idx + AW'(1);
            else                    r_idx <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_vld <= '0;
        end else if (w_busy) begin
            r_mem[r_idx] <= '0;
            r_vld[r_idx] <= 1'b0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= wr_data;
            r_vld[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_hit   <= 1'b0;
        end else if (w_rd_acc) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_bypass ? wr_data : r_mem[rd_addr];
            r_rd_hit   <= w_bypass | r_vld[rd_addr];
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_hit   <= 1'b0;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_hit   = r_rd_hit;
    assign busy     = w_busy;
    assign clr_done = (r_state == S_DONE);
endmodule
